// File: rtl/laser_multi_transmitter.sv
// Multi-lane serial laser transmitter: per-lane start/data/parity/stop framing
// with a programmable bit period and an optional lockstep mode for all lanes.
module laser_multi_transmitter #(
  parameter int NUM_LANES  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic [DIV_WIDTH-1:0]            divider,
  input  logic                            parity_en,
  input  logic                            lockstep,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_LANES-1:0]            data_valid,
  output logic [NUM_LANES-1:0]            data_ready,
  output logic [NUM_LANES-1:0]            laser_out,
  output logic [NUM_LANES-1:0]            laser_out_n,
  output logic [NUM_LANES-1:0]            busy,
  output logic [NUM_LANES-1:0]            done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } lane_state_t;

  logic [NUM_LANES-1:0] lane_idle;
  logic                 group_ready;

  // Lockstep acceptance needs every lane idle and every payload present so
  // that all lanes start on the same edge and stay bit-aligned.
  assign group_ready = en && (&lane_idle) && (&data_valid);
  assign data_ready  = lockstep ? {NUM_LANES{group_ready}}
                                : ({NUM_LANES{en}} & lane_idle);
  assign laser_out_n = ~laser_out;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_state_t           state;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_bit;
    logic                  line_q;
    logic                  done_q;
    logic                  accept;
    logic                  bit_end;

    assign accept       = data_valid[g] && data_ready[g];
    assign bit_end      = (div_cnt == div_q);
    assign lane_idle[g] = (state == ST_IDLE);
    assign busy[g]      = (state != ST_IDLE);
    assign laser_out[g] = line_q;
    assign done[g]      = done_q;

    // The line value is registered together with the state, so each branch
    // loads the level belonging to the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state    <= ST_IDLE;
        div_q    <= '0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
        par_en_q <= 1'b0;
        par_bit  <= 1'b0;
        line_q   <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (state != ST_IDLE && !en) begin
          state   <= ST_IDLE;
          line_q  <= 1'b1;
          div_cnt <= '0;
          bit_cnt <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (accept) begin
                shreg    <= data_in[g*DATA_WIDTH +: DATA_WIDTH];
                par_bit  <= ^data_in[g*DATA_WIDTH +: DATA_WIDTH];
                par_en_q <= parity_en;
                div_q    <= divider;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                line_q   <= 1'b0;
                state    <= ST_START;
              end
            end
            ST_START: begin
              if (bit_end) begin
                div_cnt <= '0;
                line_q  <= shreg[0];
                shreg   <= shreg >> 1;
                state   <= ST_DATA;
              end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
              end
            end
            ST_DATA: begin
              if (bit_end) begin
                div_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                  if (par_en_q) begin
                    line_q <= par_bit;
                    state  <= ST_PARITY;
                  end else begin
                    line_q <= 1'b1;
                    state  <= ST_STOP;
                  end
                end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  line_q  <= shreg[0];
                  shreg   <= shreg >> 1;
                end
              end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
              end
            end
            ST_PARITY: begin
              if (bit_end) begin
                div_cnt <= '0;
                line_q  <= 1'b1;
                state   <= ST_STOP;
              end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
              end
            end
            ST_STOP: begin
              if (bit_end) begin
                div_cnt <= '0;
                done_q  <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
              end
            end
            default: begin
              line_q <= 1'b1;
              state  <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_laser_multi_transmitter.sv
// Cycle-accurate scoreboard bench for laser_multi_transmitter (2 lanes, 8-bit
// payload): expected per-cycle line/busy/done levels are queued at acceptance.
module tb_laser_multi_transmitter;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic [7:0]  divider;
  logic        parity_en;
  logic        lockstep;
  logic [15:0] data_in;
  logic [1:0]  data_valid;
  logic [1:0]  data_ready;
  logic [1:0]  laser_out;
  logic [1:0]  laser_out_n;
  logic [1:0]  busy;
  logic [1:0]  done;

  typedef struct packed {
    logic [1:0] line;
    logic [1:0] done;
    logic [1:0] busy;
  } exp_t;

  localparam exp_t IDLE_EXP = '{line: 2'b11, done: 2'b00, busy: 2'b00};

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  laser_multi_transmitter #(
    .NUM_LANES (2),
    .DATA_WIDTH(8),
    .DIV_WIDTH (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .divider    (divider),
    .parity_en  (parity_en),
    .lockstep   (lockstep),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .laser_out  (laser_out),
    .laser_out_n(laser_out_n),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  // Writes one lane's expectation at a cycle offset from the queue head,
  // padding with idle cycles so the other lane's entries are preserved.
  task automatic set_item(input int k, input int lane, input logic line,
                          input logic dn, input logic bz);
    exp_t tmp;
    while (exp_q.size() <= k) exp_q.push_back(IDLE_EXP);
    tmp = exp_q[k];
    tmp.line[lane] = line;
    tmp.done[lane] = dn;
    tmp.busy[lane] = bz;
    exp_q[k] = tmp;
  endtask

  task automatic push_frame(input int lane, input logic [7:0] data,
                            input logic [7:0] div, input logic par);
    logic bits[$];
    logic p;
    int   k;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    if (par) bits.push_back(p);
    bits.push_back(1'b1);
    k = 0;
    foreach (bits[b]) begin
      for (int c = 0; c <= int'(div); c++) begin
        set_item(k, lane, bits[b], 1'b0, 1'b1);
        k++;
      end
    end
    set_item(k, lane, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic flush_lane(input int lane);
    exp_t tmp;
    for (int k = 0; k < exp_q.size(); k++) begin
      tmp = exp_q[k];
      tmp.line[lane] = 1'b1;
      tmp.done[lane] = 1'b0;
      tmp.busy[lane] = 1'b0;
      exp_q[k] = tmp;
    end
  endtask

  // Drives one offer between edges, checks ready against the bench's own
  // expectation, then queues the frames that must have been accepted.
  task automatic apply_stimulus(input logic [1:0] valid, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] div,
                                input logic par, input logic [1:0] exp_ready,
                                input bit hold);
    @(negedge clock);
    #1;
    data_in    = {d1, d0};
    data_valid = valid;
    divider    = div;
    parity_en  = par;
    #1;
    check_output("data_ready", {30'd0, data_ready}, {30'd0, exp_ready});
    @(posedge clock);
    if (valid[0] && exp_ready[0]) push_frame(0, d0, div, par);
    if (valid[1] && exp_ready[1]) push_frame(1, d1, div, par);
    #1;
    if (!hold) data_valid = 2'b00;
    divider   = 8'($urandom_range(255));
    parity_en = ~par;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = IDLE_EXP;
    check_output("laser_out",   {30'd0, laser_out},   {30'd0, e.line});
    check_output("laser_out_n", {30'd0, laser_out_n}, {30'd0, ~e.line});
    check_output("busy",        {30'd0, busy},        {30'd0, e.busy});
    check_output("done",        {30'd0, done},        {30'd0, e.done});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    en         = 1'b1;
    divider    = 8'd0;
    parity_en  = 1'b0;
    lockstep   = 1'b0;
    data_in    = 16'h0000;
    data_valid = 2'b00;

    // Reset state, ready follows en while lanes sit idle
    @(negedge clock);
    #1;
    check_output("rst_ready",  {30'd0, data_ready},  32'h3);
    check_output("rst_line",   {30'd0, laser_out},   32'h3);
    check_output("rst_line_n", {30'd0, laser_out_n}, 32'h0);
    check_output("rst_busy",   {30'd0, busy},        32'h0);
    check_output("rst_done",   {30'd0, done},        32'h0);
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;

    $display("[TB] lane0 0x12, divider 0, no parity");
    apply_stimulus(2'b01, 8'h12, 8'h00, 8'd0, 1'b0, 2'b11, 1'b0);
    repeat (14) @(posedge clock);

    $display("[TB] lane1 0x34, divider 3, parity");
    apply_stimulus(2'b10, 8'h00, 8'h34, 8'd3, 1'b1, 2'b11, 1'b0);
    repeat (50) @(posedge clock);

    $display("[TB] independent lanes with different dividers");
    apply_stimulus(2'b10, 8'h00, 8'h7E, 8'd2, 1'b0, 2'b11, 1'b0);
    repeat (2) @(posedge clock);
    apply_stimulus(2'b01, 8'hC3, 8'h00, 8'd0, 1'b1, 2'b01, 1'b0);
    repeat (40) @(posedge clock);

    $display("[TB] lockstep acceptance");
    lockstep = 1'b1;
    apply_stimulus(2'b01, 8'h5C, 8'hA3, 8'd1, 1'b1, 2'b00, 1'b0);
    repeat (3) @(posedge clock);
    apply_stimulus(2'b11, 8'h5C, 8'hA3, 8'd1, 1'b1, 2'b11, 1'b0);
    lockstep = 1'b0;
    repeat (30) @(posedge clock);

    $display("[TB] enable dropped mid-frame");
    apply_stimulus(2'b01, 8'hF0, 8'h00, 8'd1, 1'b0, 2'b11, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #1;
    en = 1'b0;
    flush_lane(0);
    #1;
    check_output("abort_ready", {30'd0, data_ready}, 32'h0);
    repeat (4) @(negedge clock);
    #1;
    en = 1'b1;
    #1;
    check_output("resume_ready", {30'd0, data_ready}, 32'h3);

    $display("[TB] asynchronous reset mid-frame");
    apply_stimulus(2'b11, 8'h81, 8'h18, 8'd2, 1'b1, 2'b11, 1'b0);
    repeat (8) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("arst_line",   {30'd0, laser_out},   32'h3);
    check_output("arst_line_n", {30'd0, laser_out_n}, 32'h0);
    check_output("arst_busy",   {30'd0, busy},        32'h0);
    check_output("arst_done",   {30'd0, done},        32'h0);
    check_output("arst_ready",  {30'd0, data_ready},  32'h3);
    exp_q.delete();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);

    $display("[TB] back-to-back frames on lane0");
    apply_stimulus(2'b01, 8'hA5, 8'h00, 8'd1, 1'b0, 2'b11, 1'b1);
    data_in[7:0] = 8'h5A;
    repeat (20) @(posedge clock);
    @(negedge clock);
    #1;
    divider   = 8'd1;
    parity_en = 1'b0;
    #1;
    check_output("b2b_ready", {30'd0, data_ready}, 32'h3);
    @(posedge clock);
    push_frame(0, 8'h5A, 8'd1, 1'b0);
    #1;
    data_valid = 2'b00;

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clock);
    check_output("drain", exp_q.size(), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/laser_multi_transmitter.md
LASER_MULTI_TRANSMITTER -- requirements
Module: laser_multi_transmitter

Interface
REQ-001 Parameter NUM_LANES, default 2: number of independent laser lanes.
REQ-002 Parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-003 Parameter DIV_WIDTH, default 8: width of the bit-period divider.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  transmit enable; low aborts in-flight frames and blocks acceptance.
REQ-007 divider  input  DIV_WIDTH  bit period = divider+1 clock cycles.
REQ-008 parity_en  input  1  1 = insert even-parity bit after data.
REQ-009 lockstep  input  1  1 = all lanes accept and start frames together.
REQ-010 data_in  input  NUM_LANES*DATA_WIDTH  lane i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 data_valid  input  NUM_LANES  per-lane payload valid.
REQ-012 data_ready  output  NUM_LANES  per-lane ready; transfer on valid&&ready at posedge.
REQ-013 laser_out  output  NUM_LANES  serial line per lane, idle high.
REQ-014 laser_out_n  output  NUM_LANES  always bitwise complement of laser_out.
REQ-015 busy  output  NUM_LANES  lane is in a non-IDLE state.
REQ-016 done  output  NUM_LANES  one-cycle pulse on normal frame completion.

Function
REQ-017 Each lane SHALL be an FSM: IDLE, START, DATA, PARITY, STOP; laser_out = 1 in IDLE/STOP, 0 in START, current data bit in DATA, parity bit in PARITY.
REQ-018 On acceptance a lane SHALL capture data_in slice and divider, clear its bit counter, and enter START the next cycle.
REQ-019 Each bit SHALL last exactly captured divider+1 cycles; divider changes mid-frame have no effect; divider=0 means one cycle per bit.
REQ-020 DATA SHALL send DATA_WIDTH bits LSB first, then PARITY if parity_en (sampled at acceptance) else STOP.
REQ-021 Parity bit SHALL equal XOR of all payload bits (even parity).
REQ-022 STOP SHALL last one bit period; lane then returns to IDLE and asserts done for that single IDLE cycle.
REQ-023 Non-lockstep: data_ready[i] = en && lane i IDLE, independent of other lanes.
REQ-024 Lockstep: data_ready[i] = en && all lanes IDLE && all data_valid high; all lanes accept on the same edge and remain bit-aligned.
REQ-025 Toggling lockstep SHALL affect acceptance only; in-flight frames complete unchanged.
REQ-026 Back-to-back: a lane accepting in its done cycle SHALL output exactly one idle-high cycle between STOP and next START.
REQ-027 en low in any non-IDLE state SHALL force IDLE on the next edge, laser_out=1, no done pulse.
REQ-028 Frame length SHALL be (10 + parity_en)... generalised: (DATA_WIDTH + 2 + parity_en) * (divider+1) cycles from START entry to STOP exit.

Reset
REQ-029 reset_n low SHALL immediately force all lanes IDLE: laser_out all 1, laser_out_n all 0, busy 0, done 0, bit counters and shift registers 0.
REQ-030 During and after reset data_ready SHALL follow REQ-023/024 from IDLE state (equals en when non-lockstep).
REQ-031 Reset asserted mid-frame SHALL discard the frame without done.

Verification (NUM_LANES=2, DATA_WIDTH=8)
REQ-032 divider=0, parity_en=0, lane0 0x12 -> laser_out[0] cycles 1-10: 0,0,1,0,0,1,0,0,0,1; done[0] pulse cycle 11; lane1 stays 1.
REQ-033 divider=3, parity_en=1, lane1 0x34 -> 11 bits of 4 cycles (44 cycles), parity bit 1, done[1] at cycle 45.
REQ-034 lockstep=1, only data_valid[0] high -> data_ready=00, lines idle; raise data_valid[1] -> both accept same edge, identical START and done cycles.
REQ-035 divider=1, frame in DATA, en dropped -> laser_out=1 next cycle, busy=0, no done; en restored -> data_ready=1.
REQ-036 reset_n low mid-frame (async, between edges) -> laser_out=11, laser_out_n=00, busy=00 immediately.
REQ-037 divider=1, valid held, 0xA5 then 0x5A on lane0 -> second accepted in done cycle, exactly one idle cycle before second START.
